// File: rtl/sweep_sched_pkg.sv
// rtl/sweep_sched_pkg.sv - shared types and constants for the sweep scheduler
package sweep_sched_pkg;

   localparam int PRESCALER_W = 14;
   localparam int SP_OUT_W    = 34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_STOP,
      ST_CPL
   } sched_state_t;

endpackage

// File: rtl/sweep_scheduler_rr_arbiter.sv
// rtl/sweep_scheduler_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         win,
   output logic [$clog2(N)-1:0] win_idx,
   output logic                 any
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] cand;

   // The scan begins one past the previous winner, so that winner is looked at last.
   always_comb begin
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last) + k) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            win_idx   = cand;
            win[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sweep_scheduler.sv
// rtl/sweep_scheduler.sv - shares one walking-one sequencer between round-robin requesters
module sweep_scheduler
   import sweep_sched_pkg::*;
#(
   parameter int N_REQ       = 2,
   parameter int SWEEP_W     = 8,
   parameter int STOP_CYCLES = 5
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic [N_REQ-1:0]               req,
   input  logic [N_REQ*PRESCALER_W-1:0]   req_prescaler,
   input  logic [N_REQ*SWEEP_W-1:0]       req_sweeps,
   input  logic                           abort,
   output logic [N_REQ-1:0]               gnt,
   output logic [N_REQ-1:0]               cpl,
   output logic                           err,
   output logic                           busy,
   output logic [$clog2(N_REQ)-1:0]       owner,
   output logic [SWEEP_W-1:0]             sweep_cnt,
   output logic                           sp_enable,
   output logic                           sp_stop,
   output logic [PRESCALER_W-1:0]         sp_prescaler,
   input  logic                           sp_done
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int STOP_W = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

   sched_state_t            state_q, state_d;
   logic [IDX_W-1:0]        owner_q, owner_d;
   logic [PRESCALER_W-1:0]  pre_q, pre_d;
   logic [SWEEP_W-1:0]      sweeps_q, sweeps_d;
   logic [SWEEP_W-1:0]      sweep_cnt_q, sweep_cnt_d;
   logic                    err_flag_q, err_flag_d;
   logic                    done_q, done_d;
   logic [STOP_W-1:0]       stop_cnt_q, stop_cnt_d;
   logic [N_REQ-1:0]        gnt_q, gnt_d;
   logic [N_REQ-1:0]        cpl_q, cpl_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic                    sp_enable_q, sp_enable_d;
   logic                    sp_stop_q, sp_stop_d;
   logic [PRESCALER_W-1:0]  sp_prescaler_q, sp_prescaler_d;

   logic [N_REQ-1:0]        arb_win;
   logic [IDX_W-1:0]        arb_idx;
   logic                    arb_any;
   logic [PRESCALER_W-1:0]  sel_pre;
   logic [SWEEP_W-1:0]      sel_sweeps;
   logic                    done_rise;

   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .req     (req),
      .last    (owner_q),
      .win     (arb_win),
      .win_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      sel_pre    = '0;
      sel_sweeps = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_win[i]) begin
            sel_pre    = req_prescaler[i*PRESCALER_W +: PRESCALER_W];
            sel_sweeps = req_sweeps[i*SWEEP_W +: SWEEP_W];
         end
      end
   end

   assign done_rise = sp_done & ~done_q;

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      pre_d          = pre_q;
      sweeps_d       = sweeps_q;
      sweep_cnt_d    = sweep_cnt_q;
      err_flag_d     = err_flag_q;
      done_d         = sp_done;
      stop_cnt_d     = stop_cnt_q;
      gnt_d          = '0;
      cpl_d          = '0;
      err_d          = 1'b0;
      sp_enable_d    = sp_enable_q;
      sp_stop_d      = sp_stop_q;
      sp_prescaler_d = sp_prescaler_q;

      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d       = arb_win;
               owner_d     = arb_idx;
               pre_d       = sel_pre;
               sweeps_d    = sel_sweeps;
               sweep_cnt_d = '0;
               if (sel_pre == '0 || sel_sweeps == '0) begin
                  err_flag_d = 1'b1;
                  state_d    = ST_CPL;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            sp_prescaler_d = pre_q;
            sp_enable_d    = 1'b0;
            sp_stop_d      = 1'b0;
            state_d        = ST_RUN;
         end
         ST_RUN: begin
            sp_enable_d = 1'b1;
            if (done_rise && sweep_cnt_q != '1) begin
               sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
            // Abort takes priority so a coincident final sweep still reports an error.
            if (abort) begin
               err_flag_d = 1'b1;
               state_d    = ST_STOP;
            end else if (sweep_cnt_q == sweeps_q) begin
               state_d = ST_STOP;
            end
            if (state_d == ST_STOP) begin
               sp_enable_d = 1'b0;
               sp_stop_d   = 1'b1;
               stop_cnt_d  = STOP_W'(STOP_CYCLES - 1);
            end
         end
         ST_STOP: begin
            if (stop_cnt_q == '0) begin
               sp_stop_d = 1'b0;
               state_d   = ST_CPL;
            end else begin
               stop_cnt_d = stop_cnt_q - 1'b1;
            end
         end
         ST_CPL: begin
            cpl_d[owner_q] = 1'b1;
            err_d          = err_flag_q;
            err_flag_d     = 1'b0;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q        <= ST_IDLE;
         owner_q        <= IDX_W'(N_REQ - 1);
         pre_q          <= '0;
         sweeps_q       <= '0;
         sweep_cnt_q    <= '0;
         err_flag_q     <= 1'b0;
         done_q         <= 1'b0;
         stop_cnt_q     <= '0;
         gnt_q          <= '0;
         cpl_q          <= '0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
         sp_enable_q    <= 1'b0;
         sp_stop_q      <= 1'b0;
         sp_prescaler_q <= '0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         pre_q          <= pre_d;
         sweeps_q       <= sweeps_d;
         sweep_cnt_q    <= sweep_cnt_d;
         err_flag_q     <= err_flag_d;
         done_q         <= done_d;
         stop_cnt_q     <= stop_cnt_d;
         gnt_q          <= gnt_d;
         cpl_q          <= cpl_d;
         err_q          <= err_d;
         busy_q         <= busy_d;
         sp_enable_q    <= sp_enable_d;
         sp_stop_q      <= sp_stop_d;
         sp_prescaler_q <= sp_prescaler_d;
      end
   end

   assign gnt          = gnt_q;
   assign cpl          = cpl_q;
   assign err          = err_q;
   assign busy         = busy_q;
   assign owner        = owner_q;
   assign sweep_cnt    = sweep_cnt_q;
   assign sp_enable    = sp_enable_q;
   assign sp_stop      = sp_stop_q;
   assign sp_prescaler = sp_prescaler_q;

endmodule

// File: tb/tb_sweep_scheduler.sv
// tb/tb_sweep_scheduler.sv - run-level checks of sweep_scheduler with a time-compressed sequencer
module tb_sweep_scheduler;
   import sweep_sched_pkg::*;

   localparam int N_REQ       = 2;
   localparam int SWEEP_W     = 8;
   localparam int STOP_CYCLES = 5;
   localparam int IDX_W       = $clog2(N_REQ);
   localparam int TICK        = 4;

   logic                         clk = 1'b0;
   logic                         nrst;
   logic [N_REQ-1:0]             req;
   logic [N_REQ*PRESCALER_W-1:0] req_prescaler;
   logic [N_REQ*SWEEP_W-1:0]     req_sweeps;
   logic                         abort;
   logic [N_REQ-1:0]             gnt;
   logic [N_REQ-1:0]             cpl;
   logic                         err;
   logic                         busy;
   logic [IDX_W-1:0]             owner;
   logic [SWEEP_W-1:0]           sweep_cnt;
   logic                         sp_enable;
   logic                         sp_stop;
   logic [PRESCALER_W-1:0]       sp_prescaler;
   logic                         sp_done;

   int pre_tab [N_REQ];
   int sw_tab  [N_REQ];
   int ref_owner;
   int errors = 0;
   int checks = 0;
   int unsigned seq_c;
   int unsigned seq_tp;

   sweep_scheduler #(
      .N_REQ       (N_REQ),
      .SWEEP_W     (SWEEP_W),
      .STOP_CYCLES (STOP_CYCLES)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .req           (req),
      .req_prescaler (req_prescaler),
      .req_sweeps    (req_sweeps),
      .abort         (abort),
      .gnt           (gnt),
      .cpl           (cpl),
      .err           (err),
      .busy          (busy),
      .owner         (owner),
      .sweep_cnt     (sweep_cnt),
      .sp_enable     (sp_enable),
      .sp_stop       (sp_stop),
      .sp_prescaler  (sp_prescaler),
      .sp_done       (sp_done)
   );

   always #50 clk = ~clk;

   // Sequencer stand-in: each walking-one slot lasts TICK*prescaler cycles instead of 10000*prescaler.
   always @(posedge clk) begin
      if (!nrst || sp_stop || !sp_enable) seq_c <= 0;
      else                                seq_c <= seq_c + 1;
   end

   assign seq_tp  = TICK * int'(sp_prescaler);
   assign sp_done = (seq_tp == 0) ? 1'b0 :
                    (sp_enable && seq_c >= seq_tp &&
                     ((seq_c - seq_tp) / seq_tp) % (SP_OUT_W + 1) == SP_OUT_W);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pack_tabs();
      for (int i = 0; i < N_REQ; i++) begin
         req_prescaler[i*PRESCALER_W +: PRESCALER_W] = PRESCALER_W'(pre_tab[i]);
         req_sweeps[i*SWEEP_W +: SWEEP_W]           = SWEEP_W'(sw_tab[i]);
      end
   endtask

   function automatic int ref_pick(input logic [N_REQ-1:0] r, input int last);
      for (int k = 1; k <= N_REQ; k++) begin
         if (r[(last + k) % N_REQ]) return (last + k) % N_REQ;
      end
      return 0;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_gnt"},       gnt, 0);
      check({tag, "_cpl"},       cpl, 0);
      check({tag, "_err"},       err, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_owner"},     owner, N_REQ - 1);
      check({tag, "_sweep_cnt"}, sweep_cnt, 0);
      check({tag, "_enable"},    sp_enable, 0);
      check({tag, "_stop"},      sp_stop, 0);
      check({tag, "_prescaler"}, sp_prescaler, 0);
   endtask

   // Serves one grant end to end; abort_at>0 raises abort once that many sweeps are counted.
   task automatic serve(input int abort_at, input bit keep_req);
      int idx, p, n, budget, t, rises, stop_at, stop_len, exp_cnt;
      bit pend;
      logic prev;
      logic [PRESCALER_W-1:0] pre_before;
      idx        = ref_pick(req, ref_owner);
      p          = pre_tab[idx];
      n          = sw_tab[idx];
      pre_before = sp_prescaler;
      for (t = 0; t < 10; t++) begin
         tick();
         if (gnt != '0) break;
      end
      check("gnt_latency", t, 0);
      check("gnt_vec", gnt, 1 << idx);
      check("gnt_owner", owner, idx);
      check("gnt_sweep_clr", sweep_cnt, 0);
      check("gnt_busy", busy, 1);
      check("gnt_cpl_low", cpl, 0);
      ref_owner = idx;
      req_prescaler[idx*PRESCALER_W +: PRESCALER_W] = PRESCALER_W'($urandom);
      req_sweeps[idx*SWEEP_W +: SWEEP_W]           = SWEEP_W'($urandom);
      if (p == 0 || n == 0) begin
         tick();
         check("inv_cpl", cpl, 1 << idx);
         check("inv_err", err, 1);
         check("inv_enable", sp_enable, 0);
         check("inv_busy", busy, 0);
         check("inv_prescaler", sp_prescaler, pre_before);
      end else begin
         tick();
         check("load_prescaler", sp_prescaler, p);
         check("load_enable", sp_enable, 0);
         tick();
         check("run_enable", sp_enable, 1);
         budget  = (n + 1) * (SP_OUT_W + 1) * TICK * p + 20;
         prev    = 1'b0;
         rises   = 0;
         pend    = 1'b0;
         stop_at = -1;
         for (t = 0; t < budget; t++) begin
            tick();
            if (sp_stop) break;
            if (pend) begin
               pend = 1'b0;
               check("sweep_cnt", sweep_cnt, rises);
               if (rises == abort_at) begin
                  abort   = 1'b1;
                  stop_at = t + 1;
               end else if (rises == n) begin
                  stop_at = t + 1;
               end
            end
            if (sp_done && !prev) begin
               rises++;
               pend = 1'b1;
            end
            prev = sp_done;
         end
         abort   = 1'b0;
         exp_cnt = (abort_at > 0) ? abort_at : n;
         check("stop_latency", t, stop_at);
         check("stop_enable", sp_enable, 0);
         check("sweep_final", sweep_cnt, exp_cnt);
         stop_len = 1;
         for (int s = 0; s < 3 * STOP_CYCLES; s++) begin
            tick();
            if (!sp_stop) break;
            stop_len++;
         end
         check("stop_len", stop_len, STOP_CYCLES);
         check("cpl_early", cpl, 0);
         tick();
         check("cpl_vec", cpl, 1 << idx);
         check("cpl_err", err, (abort_at > 0) ? 1 : 0);
         check("cpl_busy", busy, 0);
      end
      pack_tabs();
      if (!keep_req) req[idx] = 1'b0;
   endtask

   initial begin
      int idx, nsw, ab;
      nrst      = 1'b0;
      req       = '0;
      abort     = 1'b0;
      ref_owner = N_REQ - 1;
      for (int i = 0; i < N_REQ; i++) begin
         pre_tab[i] = 1;
         sw_tab[i]  = 1;
      end
      pack_tabs();
      tick();
      tick();
      check_reset("rst");
      nrst = 1'b1;

      pre_tab[0] = 1; sw_tab[0] = 2; pack_tabs();
      req[0] = 1'b1;
      serve(0, 1'b0);

      pre_tab[1] = 10; sw_tab[1] = 3; pack_tabs();
      req[1] = 1'b1;
      serve(1, 1'b0);

      pre_tab[0] = 1; sw_tab[0] = 1; pre_tab[1] = 1; sw_tab[1] = 1; pack_tabs();
      req = '1;
      serve(0, 1'b1);
      serve(0, 1'b0);
      serve(0, 1'b0);

      pre_tab[0] = 0; sw_tab[0] = 2; pack_tabs();
      req[0] = 1'b1;
      serve(0, 1'b0);
      pre_tab[0] = 1; pre_tab[1] = 1; sw_tab[1] = 2; pack_tabs();
      req[1] = 1'b1;
      serve(0, 1'b0);

      pre_tab[1] = 2; sw_tab[1] = 3; pack_tabs();
      req[1] = 1'b1;
      idx = ref_pick(req, ref_owner);
      for (int t = 0; t < 10 && gnt == '0; t++) tick();
      check("mid_gnt", gnt, 1 << idx);
      for (int t = 0; t < 50; t++) tick();
      check("mid_running", sp_enable, 1);
      nrst = 1'b0;
      tick();
      check_reset("midrst");
      tick();
      check_reset("midrst_hold");
      nrst      = 1'b1;
      ref_owner = N_REQ - 1;
      pre_tab[0] = 1; sw_tab[0] = 1; pre_tab[1] = 1; sw_tab[1] = 1; pack_tabs();
      req = '1;
      serve(0, 1'b0);
      serve(0, 1'b0);

      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               pre_tab[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 2));
               sw_tab[i]  = int'($urandom_range(1, 3));
               req[i]     = 1'b1;
            end
         end
         if (req == '0) begin
            idx          = int'($urandom_range(0, N_REQ - 1));
            pre_tab[idx] = 1;
            sw_tab[idx]  = int'($urandom_range(1, 3));
            req[idx]     = 1'b1;
         end
         pack_tabs();
         nsw = sw_tab[ref_pick(req, ref_owner)];
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, nsw)) : 0;
         serve(ab, 1'b0);
      end
      for (int i = 0; i < N_REQ && req != '0; i++) serve(0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
